// File: rtl/fetch_decode_queue_pkg.sv
// Shared constants for the fetch/decode queue: canonical NOP encoding and default depth.
package fetch_decode_queue_pkg;

  localparam int          FDQ_DEFAULT_DEPTH = 2;
  localparam logic [31:0] NOP_INSTR         = 32'h00000013;  // addi x0, x0, 0

endpackage

// File: rtl/fetch_decode_queue_storage.sv
// fdq_storage: DEPTH x WIDTH register array, one synchronous write port,
// one asynchronous read port, asynchronous active-low clear.
module fdq_storage #(
  parameter int DEPTH = 2,
  parameter int WIDTH = 64
) (
  input  logic                     clk,
  input  logic                     rst_n,
  input  logic                     wr_en,
  input  logic [$clog2(DEPTH)-1:0] wr_addr,
  input  logic [WIDTH-1:0]         wr_data,
  input  logic [$clog2(DEPTH)-1:0] rd_addr,
  output logic [WIDTH-1:0]         rd_data
);

  logic [WIDTH-1:0] mem [DEPTH];

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int i = 0; i < DEPTH; i++) mem[i] <= '0;
    end else if (wr_en) begin
      mem[wr_addr] <= wr_data;
    end
  end

  assign rd_data = mem[rd_addr];

endmodule

// File: rtl/fetch_decode_queue.sv
// Instruction buffer between fetch and decode: circular queue of {pc, instr} with
// single-cycle flush. Optional macro FDQ_NOP_BUBBLE_EN presents a NOP bubble when empty.
module fetch_decode_queue
  import fetch_decode_queue_pkg::*;
#(
  parameter int DEPTH = FDQ_DEFAULT_DEPTH,
  parameter int XLEN  = 32
) (
  input  logic                     clk,
  input  logic                     rst_n,
  input  logic                     in_valid,
  output logic                     in_ready,
  input  logic [XLEN-1:0]          in_pc,
  input  logic [XLEN-1:0]          in_instr,
  input  logic                     flush,
  output logic                     out_valid,
  input  logic                     out_ready,
  output logic [XLEN-1:0]          out_pc,
  output logic [XLEN-1:0]          out_instr,
  output logic [$clog2(DEPTH):0]   count
);

  localparam int AW = $clog2(DEPTH);
  localparam int CW = $clog2(DEPTH) + 1;

  logic [AW-1:0]     wr_ptr;
  logic [AW-1:0]     rd_ptr;
  logic [2*XLEN-1:0] rd_data;
  logic              full;
  logic              empty;
  logic              push;
  logic              pop;

  // Handshake flags depend only on the count register, never on in_valid/out_ready.
  assign full      = (count == CW'(DEPTH));
  assign empty     = (count == '0);
  assign in_ready  = !full;
  assign out_valid = !empty;
  assign push      = in_valid & in_ready;
  assign pop       = out_valid & out_ready;

  fdq_storage #(
    .DEPTH (DEPTH),
    .WIDTH (2*XLEN)
  ) u_storage (
    .clk     (clk),
    .rst_n   (rst_n),
    .wr_en   (push & ~flush),
    .wr_addr (wr_ptr),
    .wr_data ({in_pc, in_instr}),
    .rd_addr (rd_ptr),
    .rd_data (rd_data)
  );

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
    end else if (flush) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
    end else begin
      if (push) wr_ptr <= wr_ptr + AW'(1);
      if (pop)  rd_ptr <= rd_ptr + AW'(1);
      case ({push, pop})
        2'b10:   count <= count + CW'(1);
        2'b01:   count <= count - CW'(1);
        default: count <= count;
      endcase
    end
  end

`ifdef FDQ_NOP_BUBBLE_EN
  always_comb begin
    out_pc    = rd_data[2*XLEN-1:XLEN];
    out_instr = rd_data[XLEN-1:0];
    if (!out_valid) begin
      out_pc    = '0;
      out_instr = XLEN'(NOP_INSTR);
    end
  end
`else
  assign out_pc    = rd_data[2*XLEN-1:XLEN];
  assign out_instr = rd_data[XLEN-1:0];
`endif

endmodule

// File: tb/tb_fetch_decode_queue.sv
// Self-checking bench for fetch_decode_queue: directed scenarios plus randomized
// traffic against a queue-based reference model.
module tb_fetch_decode_queue;

  localparam int DEPTH = 2;
  localparam int XLEN  = 32;

  logic              clk = 1'b0;
  logic              rst_n;
  logic              in_valid;
  logic              in_ready;
  logic [XLEN-1:0]   in_pc;
  logic [XLEN-1:0]   in_instr;
  logic              flush;
  logic              out_valid;
  logic              out_ready;
  logic [XLEN-1:0]   out_pc;
  logic [XLEN-1:0]   out_instr;
  logic [$clog2(DEPTH):0] count;

  int checks = 0;
  int passes = 0;

  // Reference model: entries in arrival order, {pc, instr}.
  logic [2*XLEN-1:0] mq[$];

  fetch_decode_queue #(.DEPTH(DEPTH), .XLEN(XLEN)) dut (
    .clk       (clk),
    .rst_n     (rst_n),
    .in_valid  (in_valid),
    .in_ready  (in_ready),
    .in_pc     (in_pc),
    .in_instr  (in_instr),
    .flush     (flush),
    .out_valid (out_valid),
    .out_ready (out_ready),
    .out_pc    (out_pc),
    .out_instr (out_instr),
    .count     (count)
  );

  always #5 clk = ~clk;

  // Advance one clock, updating the model from the queue rules, then settle 1ns.
  task automatic tick();
    bit do_push, do_pop, do_flush;
    logic [2*XLEN-1:0] ent;
    do_push  = in_valid && (mq.size() < DEPTH);
    do_pop   = out_ready && (mq.size() > 0);
    do_flush = flush;
    ent      = {in_pc, in_instr};
    @(posedge clk);
    if (do_flush) mq.delete();
    else begin
      if (do_pop)  void'(mq.pop_front());
      if (do_push) mq.push_back(ent);
    end
    #1;
  endtask

  task automatic idle_inputs();
    in_valid  = 1'b0;
    in_pc     = '0;
    in_instr  = '0;
    flush     = 1'b0;
    out_ready = 1'b0;
  endtask

  task automatic test_reset();
    idle_inputs();
    rst_n = 1'b0;
    #12;
    rst_n = 1'b1;
    mq.delete();
    tick();
    checks++; if (count !== 0) $display("FAIL reset_count got=%0d want=0", count); else passes++;
    checks++; if (out_valid !== 1'b0) $display("FAIL reset_out_valid got=%b want=0", out_valid); else passes++;
    checks++; if (in_ready !== 1'b1) $display("FAIL reset_in_ready got=%b want=1", in_ready); else passes++;
`ifdef FDQ_NOP_BUBBLE_EN
    checks++; if (out_instr !== 32'h00000013) $display("FAIL reset_nop got=%h want=00000013", out_instr); else passes++;
    checks++; if (out_pc !== 32'h0) $display("FAIL reset_nop_pc got=%h want=0", out_pc); else passes++;
`endif
  endtask

  task automatic test_fill();
    out_ready = 1'b0;
    in_valid = 1'b1; in_pc = 32'h0; in_instr = 32'h00500093;
    tick();
    checks++; if (out_valid !== 1'b1 || out_pc !== 32'h0) $display("FAIL fill_first_visible got v=%b pc=%h want v=1 pc=0", out_valid, out_pc); else passes++;
    in_pc = 32'h4; in_instr = 32'h00A00113;
    tick();
    checks++; if (count !== 2) $display("FAIL fill_count got=%0d want=2", count); else passes++;
    checks++; if (in_ready !== 1'b0) $display("FAIL fill_in_ready got=%b want=0", in_ready); else passes++;
    in_pc = 32'h8; in_instr = 32'h002081B3;
    tick();
    in_valid = 1'b0;
    checks++; if (count !== 2) $display("FAIL fill_held_off got=%0d want=2", count); else passes++;
    checks++; if (out_pc !== 32'h0 || out_instr !== 32'h00500093) $display("FAIL fill_head got=%h/%h want=0/00500093", out_pc, out_instr); else passes++;
  endtask

  task automatic test_drain();
    out_ready = 1'b1;
    checks++; if (out_pc !== 32'h0) $display("FAIL drain_pc0 got=%h want=0", out_pc); else passes++;
    tick();
    checks++; if (out_pc !== 32'h4 || out_instr !== 32'h00A00113) $display("FAIL drain_pc1 got=%h/%h want=4/00A00113", out_pc, out_instr); else passes++;
    checks++; if (count !== 1) $display("FAIL drain_count1 got=%0d want=1", count); else passes++;
    tick();
    out_ready = 1'b0;
    checks++; if (count !== 0 || out_valid !== 1'b0) $display("FAIL drain_empty got c=%0d v=%b want c=0 v=0", count, out_valid); else passes++;
  endtask

  task automatic test_streaming();
    in_valid = 1'b1; out_ready = 1'b1;
    for (int i = 0; i < 10; i++) begin
      in_pc = 32'(4*i); in_instr = 32'h00000013 + 32'(i << 7);
      if (i > 0) begin
        checks++;
        if (out_valid !== 1'b1 || out_pc !== 32'(4*(i-1)))
          $display("FAIL stream_order i=%0d got v=%b pc=%h want v=1 pc=%h", i, out_valid, out_pc, 32'(4*(i-1)));
        else passes++;
      end
      tick();
      checks++; if (count !== 1) $display("FAIL stream_count i=%0d got=%0d want=1", i, count); else passes++;
    end
    in_valid = 1'b0;
    checks++; if (out_pc !== 32'h24) $display("FAIL stream_last got=%h want=24", out_pc); else passes++;
    tick();
    out_ready = 1'b0;
    checks++; if (count !== 0) $display("FAIL stream_drain got=%0d want=0", count); else passes++;
  endtask

  task automatic test_flush();
    out_ready = 1'b0; in_valid = 1'b1;
    in_pc = 32'h10; in_instr = 32'h11111111; tick();
    in_pc = 32'h14; in_instr = 32'h22222222; tick();
    checks++; if (count !== 2) $display("FAIL flush_prefill got=%0d want=2", count); else passes++;
    in_pc = 32'h200; in_instr = 32'h33333333; out_ready = 1'b1; flush = 1'b1;
    tick();
    flush = 1'b0; in_valid = 1'b0; out_ready = 1'b0;
    checks++; if (count !== 0 || out_valid !== 1'b0) $display("FAIL flush_empty got c=%0d v=%b want c=0 v=0", count, out_valid); else passes++;
    checks++; if (in_ready !== 1'b1) $display("FAIL flush_in_ready got=%b want=1", in_ready); else passes++;
    tick(); tick();
    checks++; if (out_valid !== 1'b0) $display("FAIL flush_no_ghost got v=%b pc=%h want v=0", out_valid, out_pc); else passes++;
    // Flush with count=1 and a push offered: push is lost as well.
    in_valid = 1'b1; in_pc = 32'h300; in_instr = 32'h44444444; tick();
    in_pc = 32'h304; flush = 1'b1; tick();
    flush = 1'b0; in_valid = 1'b0;
    checks++; if (count !== 0) $display("FAIL flush_push_dropped got=%0d want=0", count); else passes++;
  endtask

  task automatic test_reset_mid();
    in_valid = 1'b1; out_ready = 1'b0; in_pc = 32'h40; in_instr = 32'h55555555;
    tick();
    in_valid = 1'b0;
    checks++; if (count !== 1) $display("FAIL rstmid_pre got=%0d want=1", count); else passes++;
    #2 rst_n = 1'b0;
    #1;
    mq.delete();
    checks++; if (count !== 0 || out_valid !== 1'b0) $display("FAIL rstmid_async got c=%0d v=%b want c=0 v=0", count, out_valid); else passes++;
    checks++; if (in_ready !== 1'b1) $display("FAIL rstmid_in_ready got=%b want=1", in_ready); else passes++;
    @(negedge clk);
    rst_n = 1'b1;
    in_valid = 1'b1; in_pc = 32'h100; in_instr = 32'h00000013;
    tick();
    in_valid = 1'b0;
    checks++; if (out_valid !== 1'b1 || out_pc !== 32'h100 || out_instr !== 32'h00000013)
      $display("FAIL rstmid_head got v=%b %h/%h want v=1 100/00000013", out_valid, out_pc, out_instr); else passes++;
    out_ready = 1'b1; tick(); out_ready = 1'b0;
    checks++; if (count !== 0) $display("FAIL rstmid_drain got=%0d want=0", count); else passes++;
  endtask

  task automatic test_random();
    logic [2*XLEN-1:0] head;
    for (int n = 0; n < 400; n++) begin
      in_valid  = ($urandom_range(0, 3) != 0);
      out_ready = ($urandom_range(0, 2) != 0);
      flush     = ($urandom_range(0, 15) == 0);
      in_pc     = $urandom;
      in_instr  = $urandom;
      tick();
      checks++;
      if (int'(count) !== mq.size() || out_valid !== (mq.size() > 0) || in_ready !== (mq.size() < DEPTH))
        $display("FAIL rand_state n=%0d got c=%0d v=%b r=%b want c=%0d", n, count, out_valid, in_ready, mq.size());
      else passes++;
      if (mq.size() > 0) begin
        head = mq[0];
        checks++;
        if ({out_pc, out_instr} !== head)
          $display("FAIL rand_head n=%0d got=%h/%h want=%h/%h", n, out_pc, out_instr, head[2*XLEN-1:XLEN], head[XLEN-1:0]);
        else passes++;
      end
`ifdef FDQ_NOP_BUBBLE_EN
      else begin
        checks++;
        if (out_instr !== 32'h00000013 || out_pc !== 32'h0)
          $display("FAIL rand_bubble n=%0d got=%h/%h want=0/00000013", n, out_pc, out_instr);
        else passes++;
      end
`endif
    end
    idle_inputs();
  endtask

  initial begin
    test_reset();
    test_fill();
    test_drain();
    test_streaming();
    test_flush();
    test_reset_mid();
    test_random();
    $display("%0d/%0d checks passed", passes, checks);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL timeout got=running want=finished");
    $fatal(1, "timeout");
  end

endmodule

// File: doc/fetch_decode_queue.md
# fetch_decode_queue

- Pipeline buffer between instruction fetch and decode.
- Accepts {PC, instruction} pairs from the fetch side under a valid/ready handshake and holds up to DEPTH of them.
- Presents the oldest entry to the decode stage. Decode slices out_instr[31:7] for immediate generation and out_instr[6:0] for opcode decode.
- Decouples fetch from decode stalls and supports a single-cycle flush on branch/jump redirect.

## Interface
- DEPTH, 2: number of entries; power of two, 2..8.
- XLEN, 32: PC and instruction width.
- clk  in  1  single clock; all state changes on rising edge.
- rst_n  in  1  reset, asynchronous and active-low.
- in_valid  in  1  fetch offers an entry.
- in_ready  out  1  queue can accept; equals !full.
- in_pc  in  XLEN  PC of offered instruction.
- in_instr  in  XLEN  offered instruction word.
- flush  in  1  discard all entries (redirect from EX).
- out_valid  out  1  oldest entry available; equals !empty.
- out_ready  in  1  decode consumes the entry this cycle.
- out_pc  out  XLEN  PC of oldest entry.
- out_instr  out  XLEN  instruction of oldest entry.
- count  out  $clog2(DEPTH)+1  current occupancy.

## Operation
- Circular buffer with wr_ptr and rd_ptr of $clog2(DEPTH) bits, plus count.
- Pointers wrap modulo DEPTH.
- push = in_valid & in_ready; pop = out_valid & out_ready.
- Push only: store at wr_ptr, wr_ptr+1, count+1.
- Pop only: rd_ptr+1, count-1.
- Push and pop together (only possible when 0 < count < DEPTH): both pointers advance, count unchanged.
- Full (count==DEPTH):
  - in_ready=0, and a push is not accepted even if a pop occurs that cycle.
  - There is no fall-through path from in_ready to out_ready.
- Empty (count==0): out_valid=0. A pushed entry is not bypassed to the output in the same cycle.
- Flush has priority over push and pop:
  - At the next edge, wr_ptr=rd_ptr=0 and count=0.
  - Any push or pop in the flush cycle is discarded.
  - in_ready stays driven as !full during the flush cycle; fetch must treat its flush-cycle transfer as lost.
- out_pc and out_instr read storage at rd_ptr and are combinational from registers only.
- Reset (rst_n low, asynchronous):
  - count=0 and pointers=0, so out_valid=0 and in_ready=1.
  - Storage is cleared to 0.
- Reset asserted mid-transfer: all entries are lost; the first accepted push after rst_n rises is the head.

## Timing
- Latency: an entry pushed at edge N is visible with out_valid=1 after edge N; minimum 1 cycle from fetch to decode.
- Throughput: one push and one pop per cycle in steady state.
- in_ready and out_valid are pure functions of the count register, so there are no combinational paths from in_valid or out_ready.
- After a flush at edge N, out_valid=0 and in_ready=1 following edge N.

## Configuration
- FDQ_NOP_BUBBLE_EN:
  - Defined: when out_valid=0, out_instr is forced to 32'h00000013 (addi x0,x0,0) and out_pc to 0, so decode sees a clean bubble.
  - Undefined: out_instr and out_pc show storage[rd_ptr] unconditionally and are don't-care while out_valid=0.
- Reset values of storage are 0 in both builds.

## Structure
- Shared package (alongside Parameters.v): NOP instruction constant 32'h00000013 and FDQ_DEFAULT_DEPTH.
- One sub-module, fdq_storage: DEPTH×(2·XLEN) register array with one write port and one asynchronous read port, async active-low clear.
- Pointer/count logic and the handshake stay in the top.

## Test plan
- Reset, then idle:
  - count=0, out_valid=0, in_ready=1.
  - With FDQ_NOP_BUBBLE_EN, out_instr=32'h00000013.
- Fill with out_ready=0, DEPTH=2:
  - Push (pc 0x0, instr 0x00500093) then (0x4, 0x00A00113).
  - Response: count=2, in_ready=0; a third push of (0x8, 0x002081B3) is held off.
- Drain after fill:
  - out_ready=1 for two cycles.
  - out_pc 0x0 then 0x4 in order; count reaches 0 and out_valid=0.
- Streaming:
  - in_valid=out_ready=1 continuously for 10 entries with PC 0x0..0x24.
  - After the first entry, one entry out per cycle in PC order; count stays 1.
- Flush with count=2, simultaneous push and pop:
  - Next cycle count=0 and out_valid=0.
  - The pushed entry never appears at the output.
- rst_n asserted mid-stream with count=1:
  - count=0 immediately (asynchronous).
  - After release, the first push (0x100, 0x00000013) is the head.
